counter_sweep_ctrl: RTL

- Sequencer for the shared 8-bit up/down counter: drives its Enable/Load/UpDn/Data pins and watches its Q output.
- Runs triangle sweeps Lo -> Hi -> Lo for a programmed number of passes, or continuously.
- Sits between the test-pattern command logic (Start/Stop/Pause) and the counter instance; it is the counter's only driver.

---
 rtl/counter_sweep_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: sequencer for the shared up/down counter.
// Runs triangle sweeps Lo -> Hi -> Lo for a programmed number of passes
// (0 = continuous) and is the counter's only driver.
//
// Ports:
//   Clock, ResetN            clock (rising edge), async active-low reset
//   Start, Stop, Pause       command inputs (Stop dominates, Pause freezes)
//   Lo, Hi, Passes           sweep bounds and pass count, sampled on Start
//   CntQ                     counter output value
//   CntEnable, CntLoad,      counter control, decoded combinationally
//   CntUpDn, CntData         from state, CntQ, Pause and Stop
//   Busy, Done, Err, PassCnt registered status
module counter_sweep_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PASS_W = 8
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Pause,
    input  logic [WIDTH-1:0]  Lo,
    input  logic [WIDTH-1:0]  Hi,
    input  logic [PASS_W-1:0] Passes,
    input  logic [WIDTH-1:0]  CntQ,
    output logic              CntEnable,
    output logic              CntLoad,
    output logic              CntUpDn,
    output logic [WIDTH-1:0]  CntData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [PASS_W-1:0] PassCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    lo_q;
    logic [WIDTH-1:0]    hi_q;
    logic [PASS_W-1:0]   passes_q;

    logic                at_hi;
    logic                at_lo;
    logic [PASS_W-1:0]   pass_next;
    logic                pass_last;

    assign at_hi     = (CntQ == hi_q);
    assign at_lo     = (CntQ == lo_q);
    // Wraps at 2^PASS_W; a zero programmed count never matches, so runs forever.
    assign pass_next = PassCnt + PASS_W'(1);
    assign pass_last = (passes_q != '0) && (pass_next == passes_q);

    // Counter control decode: turns at the bounds issue the reverse step in
    // the same cycle, so the sweep has no dwell at either end.
    always_comb begin
        CntEnable = 1'b0;
        CntLoad   = 1'b0;
        CntUpDn   = 1'b0;
        CntData   = '0;
        if (!Stop) begin
            unique case (state)
                S_LOAD: begin
                    CntEnable = 1'b1;
                    CntLoad   = 1'b1;
                    CntData   = lo_q;
                end
                S_UP: begin
                    if (!Pause) begin
                        CntEnable = 1'b1;
                        CntUpDn   = !at_hi;
                    end
                end
                S_DOWN: begin
                    if (!Pause) begin
                        if (!at_lo) begin
                            CntEnable = 1'b1;
                        end else if (!pass_last) begin
                            CntEnable = 1'b1;
                            CntUpDn   = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State sequencing and registered status outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
            PassCnt  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            if (Stop && state != S_IDLE) begin
                // Abort: PassCnt keeps the passes completed so far.
                state <= S_IDLE;
                Busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (Start && !Stop) begin
                            if (Lo < Hi) begin
                                lo_q     <= Lo;
                                hi_q     <= Hi;
                                passes_q <= Passes;
                                PassCnt  <= '0;
                                state    <= S_LOAD;
                                Busy     <= 1'b1;
                            end else begin
                                Err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        state <= S_UP;
                    end
                    S_UP: begin
                        if (!Pause && at_hi) begin
                            state <= S_DOWN;
                        end
                    end
                    S_DOWN: begin
                        if (!Pause && at_lo) begin
                            PassCnt <= pass_next;
                            if (pass_last) begin
                                state <= S_DONE;
                                Done  <= 1'b1;
                            end else begin
                                state <= S_UP;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
